// File: rtl/uart_block_sender.sv
// uart_block_sender: streams an image out of a 1-cycle-latency buffer as
// framed 8x8 blocks (HEADER, id, total, payload, FOOTER) to a byte UART TX.
module uart_block_sender #(
  parameter int          IMG_W   = 32,
  parameter int          IMG_H   = 32,
  parameter int          BLOCK_W = 8,
  parameter int          BLOCK_H = 8,
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter logic [7:0]  FOOTER  = 8'h55
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               mem_rd_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0]     mem_addr,
  input  logic [7:0]                         mem_rdata,
  output logic [7:0]                         tx_data,
  output logic                               tx_start,
  input  logic                               tx_busy
);

  localparam int AW        = $clog2(IMG_W*IMG_H);
  localparam int BLK_COLS  = IMG_W / BLOCK_W;
  localparam int TOTAL     = BLK_COLS * (IMG_H / BLOCK_H);
  localparam int FRAME_LEN = BLOCK_W * BLOCK_H + 4;
  localparam int IW        = $clog2(FRAME_LEN);
  localparam int CW        = $clog2(BLOCK_W + 1);
  localparam int KW        = $clog2(BLK_COLS + 1);
  localparam int BW        = $clog2(TOTAL + 1);

  localparam logic [IW-1:0] LAST_IDX     = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] PC_LAST      = CW'(BLOCK_W - 1);
  localparam logic [KW-1:0] BC_LAST      = KW'(BLK_COLS - 1);
  localparam logic [BW-1:0] BLK_LAST     = BW'(TOTAL - 1);
  localparam logic [7:0]    TOTAL_B      = 8'(TOTAL);
  // Address steps: next pixel, wrap to the next row inside a block,
  // next block to the right, and wrap to the first block of the next block row.
  localparam logic [AW-1:0] PIX_STEP     = AW'(1);
  localparam logic [AW-1:0] PIX_ROW_STEP = AW'(IMG_W - BLOCK_W + 1);
  localparam logic [AW-1:0] BLK_STEP     = AW'(BLOCK_W);
  localparam logic [AW-1:0] BLK_ROW_STEP = AW'((BLOCK_H - 1) * IMG_W + BLOCK_W);

  typedef enum logic [2:0] {IDLE, NEXT, DATA, ACK, DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   byte_idx;   // position inside the current frame
  logic [CW-1:0]   pc;         // payload column inside the block
  logic [KW-1:0]   bc;         // block column of the current block
  logic [BW-1:0]   blk;        // current block id
  logic [AW-1:0]   blk_base;   // address of the block's top-left pixel
  logic [AW-1:0]   pix_addr;   // address of the next payload pixel
  logic            is_payload;
  logic [7:0]      ctrl_byte;

  // Classify the current frame position and pick the non-payload byte.
  always_comb begin
    is_payload = (byte_idx >= IW'(3)) && (byte_idx != LAST_IDX);
    ctrl_byte  = FOOTER;
    if (byte_idx == '0)
      ctrl_byte = HEADER;
    else if (byte_idx == IW'(1))
      ctrl_byte = 8'(blk);
    else if (byte_idx == IW'(2))
      ctrl_byte = TOTAL_B;
  end

  // Frame sequencer: byte handshake with the transmitter and buffer reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_start  <= 1'b0;
      mem_rd_en <= 1'b0;
      tx_data   <= '0;
      mem_addr  <= '0;
      byte_idx  <= '0;
      pc        <= '0;
      bc        <= '0;
      blk       <= '0;
      blk_base  <= '0;
      pix_addr  <= '0;
    end else begin
      tx_start  <= 1'b0;
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            busy     <= 1'b1;
            byte_idx <= '0;
            pc       <= '0;
            bc       <= '0;
            blk      <= '0;
            blk_base <= '0;
            pix_addr <= '0;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (!tx_busy) begin
            if (is_payload) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= pix_addr;
              state     <= DATA;
            end else begin
              tx_data  <= ctrl_byte;
              tx_start <= 1'b1;
              state    <= ACK;
            end
          end
        end
        DATA: begin
          tx_data  <= mem_rdata;
          tx_start <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          // Gives the transmitter a cycle to raise tx_busy.
          state <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (is_payload) begin
              if (pc == PC_LAST) begin
                pc       <= '0;
                pix_addr <= pix_addr + PIX_ROW_STEP;
              end else begin
                pc       <= pc + CW'(1);
                pix_addr <= pix_addr + PIX_STEP;
              end
            end
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              pc       <= '0;
              if (blk == BLK_LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                blk <= blk + BW'(1);
                if (bc == BC_LAST) begin
                  bc       <= '0;
                  blk_base <= blk_base + BLK_ROW_STEP;
                  pix_addr <= blk_base + BLK_ROW_STEP;
                end else begin
                  bc       <= bc + KW'(1);
                  blk_base <= blk_base + BLK_STEP;
                  pix_addr <= blk_base + BLK_STEP;
                end
                state <= NEXT;
              end
            end else begin
              byte_idx <= byte_idx + IW'(1);
              state    <= NEXT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_block_sender.sv
// Testbench for uart_block_sender: random-latency transmitter model, image
// buffer model, and a frame-level reference built from block/pixel arithmetic.
module tb_uart_block_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: default 32x32 image ----------------
  logic       reset, start;
  logic       busy_a, done_a, mem_rd_en_a, tx_start_a, tx_busy_a;
  logic [9:0] mem_addr_a;
  logic [7:0] mem_rdata_a, tx_data_a;
  logic [7:0] mem_a [0:1023];

  uart_block_sender dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a)
  );

  assign mem_rdata_a = mem_a[mem_addr_a];

  // ---------------- DUT B: 16x8 image variant ----------------
  logic       start_b;
  logic       busy_b, done_b, mem_rd_en_b, tx_start_b, tx_busy_b;
  logic [6:0] mem_addr_b;
  logic [7:0] mem_rdata_b, tx_data_b;

  uart_block_sender #(.IMG_W(16), .IMG_H(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b)
  );

  assign mem_rdata_b = 8'(mem_addr_b) ^ 8'h3C;

  // ---------------- transmitter models ----------------
  int lat_min = 20;
  int lat_max = 20;
  int cnt_a = 0;
  int cnt_b = 0;

  always @(posedge clk) begin
    if (tx_start_a) cnt_a <= int'($urandom_range(lat_max, lat_min));
    else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (tx_start_b) cnt_b <= 2;
    else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign tx_busy_a = (cnt_a != 0);
  assign tx_busy_b = (cnt_b != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // sel 0: buffer A contents; sel 1: DUT B's address-derived pixels.
  function automatic logic [7:0] pix_val(input int sel, input int addr);
    if (sel == 0) return mem_a[addr];
    return 8'(addr) ^ 8'h3C;
  endfunction

  function automatic logic [7:0] exp_byte(input int iw, input int ih, input int k, input int sel);
    int fl, total, b, i, p, br, bc, addr;
    fl    = 8 * 8 + 4;
    total = (iw / 8) * (ih / 8);
    b     = k / fl;
    i     = k % fl;
    if (i == 0)      return 8'hAA;
    if (i == 1)      return 8'(b);
    if (i == 2)      return 8'(total);
    if (i == fl - 1) return 8'h55;
    p    = i - 3;
    br   = b / (iw / 8);
    bc   = b % (iw / 8);
    addr = (br * 8 + p / 8) * iw + bc * 8 + p % 8;
    return pix_val(sel, addr);
  endfunction

  // ---------------- monitors (sample on the falling edge) ----------------
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  int         rda_b [$];
  int         done_cnt_a = 0;
  int         done_cnt_b = 0;
  logic       prev_txs = 1'b0, prev_rd = 1'b0, prev_rst = 1'b1, prev_busy = 1'b0;
  logic [9:0] prev_addr = '0;

  always @(negedge clk) begin
    if (tx_start_a) begin
      cap_a.push_back(tx_data_a);
      check("txs_while_busy", 32'(tx_busy_a), 32'd0);
      check("txs_back_to_back", 32'(prev_txs), 32'd0);
    end
    if (prev_rd && !prev_rst) begin
      check("rd_then_txs", 32'(tx_start_a), 32'd1);
      check("rd_data_fwd", 32'(tx_data_a), 32'(mem_a[prev_addr]));
    end
    if (done_a) begin
      done_cnt_a++;
      check("done_busy_low", 32'(busy_a), 32'd0);
      check("busy_fell_with_done", 32'(prev_busy), 32'd1);
    end
    if (tx_start_b) cap_b.push_back(tx_data_b);
    if (mem_rd_en_b) rda_b.push_back(int'(mem_addr_b));
    if (done_b) done_cnt_b++;
    prev_txs  = tx_start_a;
    prev_rd   = mem_rd_en_a;
    prev_addr = mem_addr_a;
    prev_rst  = reset;
    prev_busy = busy_a;
  end

  // ---------------- full-image run on DUT A ----------------
  task automatic run_image(input int mode, input bit poke, input bit dpoke);
    int  cyc, nmis;
    bit  poked, hdr_ok;
    for (int a = 0; a < 1024; a++) begin
      case (mode)
        0:       mem_a[a] = 8'(a);
        1:       mem_a[a] = 8'hAA;
        2:       mem_a[a] = 8'h55;
        default: mem_a[a] = 8'($urandom);
      endcase
    end
    cap_a.delete();
    done_cnt_a = 0;
    poked = 1'b0;
    hdr_ok = !tx_busy_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy_a), 32'd1);
    if (hdr_ok) begin
      tick();
      check("hdr_strobe", {23'd0, tx_start_a, tx_data_a}, {23'd0, 1'b1, 8'hAA});
    end
    cyc = 0;
    while (!done_a && cyc < 40000) begin
      start = poke && !poked && (cap_a.size() >= 3 * 68 + 10);
      if (start) poked = 1'b1;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_a), 32'd1);
    check("bytes_at_done", 32'(cap_a.size()), 32'd1088);
    if (dpoke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done_ignored", 32'(busy_a), 32'd0);
    end
    repeat (4) tick();
    check("byte_count", 32'(cap_a.size()), 32'd1088);
    check("done_once", 32'(done_cnt_a), 32'd1);
    nmis = 0;
    for (int k = 0; k < cap_a.size() && k < 1088; k++)
      if (cap_a[k] !== exp_byte(32, 32, k, 0)) nmis++;
    check("stream_match", 32'(nmis), 32'd0);
    if (mode == 0 && cap_a.size() == 1088) begin
      check("f0_hdr",   32'(cap_a[0]),  32'hAA);
      check("f0_id",    32'(cap_a[1]),  32'h00);
      check("f0_total", 32'(cap_a[2]),  32'h10);
      check("f0_p0",    32'(cap_a[3]),  32'h00);
      check("f0_p8",    32'(cap_a[11]), 32'h20);
      check("f0_p63",   32'(cap_a[66]), 32'hE7);
      check("f0_ftr",   32'(cap_a[67]), 32'h55);
      check("f5_p0",    32'(cap_a[5 * 68 + 3]), 32'h08);
      check("f5_p1",    32'(cap_a[5 * 68 + 4]), 32'h09);
    end
    if (mode == 1 || mode == 2) begin
      nmis = 0;
      for (int p = 0; p < 64; p++)
        if (cap_a[7 * 68 + 3 + p] !== mem_a[0]) nmis++;
      check("f7_verbatim_payload", 32'(nmis), 32'd0);
      check("f7_id", 32'(cap_a[7 * 68 + 1]), 32'h07);
    end
  endtask

  initial begin
    int cyc, held;
    reset = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    check("rst_busy",    32'(busy_a),      32'd0);
    check("rst_done",    32'(done_a),      32'd0);
    check("rst_txs",     32'(tx_start_a),  32'd0);
    check("rst_rd",      32'(mem_rd_en_a), 32'd0);
    check("rst_tx_data", 32'(tx_data_a),   32'd0);
    check("rst_addr",    32'(mem_addr_a),  32'd0);
    reset = 1'b0;
    tick();

    run_image(0, 1'b0, 1'b0);
    lat_min = 1;
    lat_max = 4;
    run_image(1, 1'b0, 1'b0);
    run_image(2, 1'b0, 1'b0);
    run_image(3, 1'b1, 1'b1);

    // Reset during block 2, payload byte 30, then restart.
    for (int a = 0; a < 1024; a++) mem_a[a] = 8'(a);
    cap_a.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cap_a.size() < 2 * 68 + 3 + 31 && cyc < 40000) begin
      tick();
      cyc++;
    end
    check("reached_blk2_p30", 32'(cap_a.size()), 32'(2 * 68 + 3 + 31));
    reset = 1'b1;
    tick();
    check("midrst_txs",  32'(tx_start_a),  32'd0);
    check("midrst_busy", 32'(busy_a),      32'd0);
    check("midrst_rd",   32'(mem_rd_en_a), 32'd0);
    held = cap_a.size();
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check("no_txs_after_rst", 32'(cap_a.size()), 32'(held));
    check("idle_after_rst", 32'(busy_a), 32'd0);
    run_image(0, 1'b0, 1'b0);
    check("restart_hdr", 32'(cap_a[0]), 32'hAA);
    check("restart_id",  32'(cap_a[1]), 32'h00);

    // Parameter variant: 16x8 image, two blocks.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy", 32'(busy_b), 32'd1);
    cyc = 0;
    while (!done_b && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("b_done_seen", 32'(done_b), 32'd1);
    repeat (4) tick();
    check("b_bytes", 32'(cap_b.size()), 32'd136);
    check("b_done_once", 32'(done_cnt_b), 32'd1);
    if (cap_b.size() == 136) begin
      check("b_f1_hdr",   32'(cap_b[68]), 32'hAA);
      check("b_f1_id",    32'(cap_b[69]), 32'h01);
      check("b_f1_total", 32'(cap_b[70]), 32'h02);
      cyc = 0;
      for (int k = 0; k < 136; k++)
        if (cap_b[k] !== exp_byte(16, 8, k, 1)) cyc++;
      check("b_stream_match", 32'(cyc), 32'd0);
    end
    if (rda_b.size() > 64)
      check("b_f1_first_addr", 32'(rda_b[64]), 32'd8);
    check("b_rd_count", 32'(rda_b.size()), 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_block_sender.md
# uart_block_sender

Host-side counterpart of the FPGA block receiver: streams a grayscale image out over UART as framed 8x8 blocks, in exactly the format the receiver's RX FSM consumes. It sits between an image buffer (synchronous 1-cycle-latency read port) and a `uart_tx_module`-style byte transmitter. It is used in loopback benches and in a second FPGA acting as image source. Each block is sent as one frame: header, block id, total-block count, payload, footer.

## Interface
- `IMG_W`, 32, image width in pixels (multiple of `BLOCK_W`)
- `IMG_H`, 32, image height in pixels (multiple of `BLOCK_H`)
- `BLOCK_W`, 8, block width
- `BLOCK_H`, 8, block height
- `HEADER`, 8'hAA, frame start byte
- `FOOTER`, 8'h55, frame end byte
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to send the whole image; ignored while `busy`=1
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last footer has finished transmitting
- `mem_rd_en`  out  1  image buffer read strobe
- `mem_addr`  out  $clog2(IMG_W*IMG_H)  raster pixel address (row*IMG_W+col)
- `mem_rdata`  in  8  pixel byte, valid the cycle after `mem_rd_en`
- `tx_data`  out  8  byte to transmitter
- `tx_start`  out  1  one-cycle send strobe
- `tx_busy`  in  1  transmitter busy; high no later than the cycle after `tx_start`

## Operation
- TOTAL = (IMG_W/BLOCK_W)*(IMG_H/BLOCK_H). Blocks are sent in id order 0..TOTAL-1. Block id b gives br=b/(IMG_W/BLOCK_W) and bc=b%(IMG_W/BLOCK_W).
- Frame byte sequence, BLOCK_W*BLOCK_H+4 bytes: `HEADER`, b[7:0], TOTAL[7:0], payload, `FOOTER`.
- Payload index p = 0..BLOCK_W*BLOCK_H-1 maps to address (br*BLOCK_H + p/BLOCK_W)*IMG_W + bc*BLOCK_W + p%BLOCK_W. This is row-major within the block. Use incremental row/col counters; no dividers.
- Payload bytes are sent verbatim, with no escaping. Payload values equal to `HEADER` or `FOOTER` are legal.
- States:
  - IDLE: on `start`, clear counters, set `busy`, go to NEXT.
  - NEXT: stall while `tx_busy`=1. When `tx_busy`=0:
    - if the current byte is payload, pulse `mem_rd_en` with `mem_addr`, then go to DATA;
    - otherwise load the constant or id byte into `tx_data`, pulse `tx_start`, then go to ACK.
  - DATA: `tx_data`<=`mem_rdata`, pulse `tx_start`, go to ACK.
  - ACK: one cycle unconditional, so the transmitter can raise `tx_busy`. Go to DRAIN.
  - DRAIN: wait for `tx_busy`=0, then advance the byte and block counters.
    - After the footer of block TOTAL-1: pulse `done`, clear `busy`, go to IDLE.
    - Otherwise go to NEXT.
- `tx_data` holds its value between strobes. `mem_addr` is don't-care when `mem_rd_en`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `tx_start`=0, `mem_rd_en`=0, `tx_data`=0, `mem_addr`=0, state IDLE.
- All outputs are registered.
- Start-up: `start` sampled at edge k sets `busy`=1 after edge k. With `tx_busy` low, `tx_start`/`HEADER` is high after edge k+1.
- Payload byte: `mem_rd_en` high after edge n; `mem_rdata` sampled at edge n+1; `tx_start` high after edge n+1.
- `tx_start` is never high on two consecutive cycles. It is never asserted while `tx_busy`=1.
- `done` is high for exactly one cycle, in the same cycle `busy` falls. `start` in that cycle is ignored. `start` is accepted the following cycle.
- `start` while `busy`=1 has no effect, including mid-frame.
- `reset` mid-frame: all outputs reach reset values after that edge. No further `tx_start` or `mem_rd_en` is issued. A partial frame is allowed; the receiver resyncs on the next `HEADER`.
- `tx_busy` stuck high stalls the block indefinitely in NEXT or DRAIN, with no timeout.
- Total bytes per image = TOTAL*(BLOCK_W*BLOCK_H+4). With defaults: 16*68=1088.

## Test plan
- Full image, default parameters:
  - Stimulus: memory holds pixel[a]=a[7:0]; TX model with 20-cycle busy; pulse `start`.
  - Required: exactly 1088 bytes.
  - Frame 0 is AA,00,10,00..07,20..27,…,E0..E7,55.
  - Frame 5 payload begins 08,09,…; `done` pulses once after the last 55.
- Byte-level handshake:
  - Stimulus: check every `tx_start`.
  - Required: `tx_busy`=0 at each `tx_start`; no back-to-back strobes; every `mem_rd_en` is followed one cycle later by `tx_start` carrying `mem_rdata`.
- Payload equal to framing bytes:
  - Stimulus: all pixels = 8'hAA, then all pixels = 8'h55.
  - Required: 64 verbatim AA (or 55) payload bytes per frame; frame structure unchanged.
- `start` during operation:
  - Stimulus: pulse `start` during block 3 payload.
  - Required: stream unchanged, still 1088 bytes, single `done`.
- Reset mid-frame:
  - Stimulus: assert `reset` during block 2 payload byte 30, then send a new `start`.
  - Required: `tx_start`, `busy`, `mem_rd_en` are 0 after the reset edge; the new stream restarts at AA,00.
- Parameter variant:
  - Stimulus: IMG_W=16, IMG_H=8, BLOCK 8x8.
  - Required: TOTAL=2, 136 bytes; frame 1 header AA,01,02; first payload address = 8.
